// File: rtl/mult_pkg.sv
// Shared types for the multiplier job sequencer: operand widths, FSM states
// and the queued job record.
package mult_pkg;

    localparam int JOB_DATA_W = 32;
    localparam int JOB_PROD_W = 2 * JOB_DATA_W;
    localparam int JOB_TAG_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic [JOB_DATA_W-1:0] a;
        logic [JOB_DATA_W-1:0] b;
        logic [JOB_TAG_W-1:0]  tag;
    } mult_job_t;

endpackage

// File: rtl/mult_op_fifo.sv
// Synchronous FIFO of operand-pair jobs. The read side is show-ahead: rdata
// always presents the head entry while the FIFO is non-empty.
module mult_op_fifo
    import mult_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  mult_job_t        wdata,
    input  logic             pop,
    output mult_job_t        rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    mult_job_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    // A push is refused when full even if a pop frees a slot on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mult_job_sequencer.sv
// Queues signed operand pairs, issues them one at a time to a shift-add
// multiplier and returns tagged results in order. Define MULT_TIMEOUT_EN to
// add a watchdog that aborts a job whose multiplier never reports done.
module mult_job_sequencer
    import mult_pkg::*;
#(
    parameter int DATA_W         = JOB_DATA_W,
    parameter int TAG_W          = JOB_TAG_W,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 80
) (
    input  logic                    clk,
    input  logic                    rst,
    // Both ports use valid/ready: a transfer happens on any posedge where
    // valid and ready are both high; valid holds, with data stable, until it.
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_a,
    input  logic [DATA_W-1:0]       in_b,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    mul_start,
    output logic [DATA_W-1:0]       mul_a,
    output logic [DATA_W-1:0]       mul_b,
    input  logic [2*DATA_W-1:0]     mul_product,
    input  logic                    mul_done,
    input  logic                    mul_overflow,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [2*DATA_W-1:0]     res_product,
    output logic                    res_overflow,
    output logic                    res_err,
    output logic [TAG_W-1:0]        res_tag,
    output logic                    busy,
    output logic [15:0]             jobs_done,
    output seq_state_e              fsm_state,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("mult_job_sequencer: DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 1");
    end

    seq_state_e       state;
    mult_job_t        fifo_wdata;
    mult_job_t        fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [TAG_W-1:0] tag_q;

    assign fifo_wdata.a   = in_a;
    assign fifo_wdata.b   = in_b;
    assign fifo_wdata.tag = in_tag;

    // The head leaves the FIFO on the same edge it is loaded into mul_a/mul_b.
    assign fifo_pop = (state == IDLE) && !fifo_empty;

    mult_op_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign in_ready  = !fifo_full;
    assign busy      = (state != IDLE) || !fifo_empty;
    assign fsm_state = state;

`ifdef MULT_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            mul_start    <= 1'b0;
            mul_a        <= '0;
            mul_b        <= '0;
            tag_q        <= '0;
            res_valid    <= 1'b0;
            res_product  <= '0;
            res_overflow <= 1'b0;
            res_err      <= 1'b0;
            res_tag      <= '0;
            jobs_done    <= '0;
`ifdef MULT_TIMEOUT_EN
            wd_cnt       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        mul_a     <= fifo_head.a;
                        mul_b     <= fifo_head.b;
                        tag_q     <= fifo_head.tag;
                        mul_start <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mul_start <= 1'b0;
`ifdef MULT_TIMEOUT_EN
                    wd_cnt    <= '0;
`endif
                    state     <= WAIT;
                end
                WAIT: begin
                    // A done arriving on the expiry edge still wins over the abort.
                    if (mul_done) begin
                        res_product  <= mul_product;
                        res_overflow <= mul_overflow;
                        res_err      <= 1'b0;
                        res_tag      <= tag_q;
                        res_valid    <= 1'b1;
                        jobs_done    <= jobs_done + 1'b1;
                        state        <= HOLD;
                    end
`ifdef MULT_TIMEOUT_EN
                    else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        res_product  <= '0;
                        res_overflow <= 1'b0;
                        res_err      <= 1'b1;
                        res_tag      <= tag_q;
                        res_valid    <= 1'b1;
                        jobs_done    <= jobs_done + 1'b1;
                        state        <= HOLD;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_job_sequencer.sv
// Directed bench for mult_job_sequencer with a behavioural multiplier that
// answers a start pulse after a fixed latency; can hang or force a product.
module tb_mult_job_sequencer;
    import mult_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [3:0]  in_tag;
    logic        mul_start;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_product;
    logic        mul_done;
    logic        mul_overflow;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_product;
    logic        res_overflow;
    logic        res_err;
    logic [3:0]  res_tag;
    logic        busy;
    logic [15:0] jobs_done;
    seq_state_e  fsm_state;
    logic [2:0]  fifo_count;

    int pass_cnt = 0;
    int total    = 0;
    int start_cnt = 0;

    logic [63:0] exp_q[$];
    logic [3:0]  exp_tag_q[$];

    always #5 clk = ~clk;

    mult_job_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_tag       (in_tag),
        .mul_start    (mul_start),
        .mul_a        (mul_a),
        .mul_b        (mul_b),
        .mul_product  (mul_product),
        .mul_done     (mul_done),
        .mul_overflow (mul_overflow),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_product  (res_product),
        .res_overflow (res_overflow),
        .res_err      (res_err),
        .res_tag      (res_tag),
        .busy         (busy),
        .jobs_done    (jobs_done),
        .fsm_state    (fsm_state),
        .fifo_count   (fifo_count)
    );

    // Behavioural multiplier: done pulses 4 cycles after the start edge.
    logic        mdl_hang = 1'b0;
    logic        mdl_ovr_en = 1'b0;
    logic [63:0] mdl_ovr_p = '0;
    logic [63:0] mdl_p;
    logic        mdl_done;
    logic        mdl_busy;
    int          mdl_lat;

    always @(posedge clk) begin
        mdl_done <= 1'b0;
        if (rst) begin
            mdl_busy <= 1'b0;
            mdl_lat  <= 0;
        end else if (mul_start) begin
            mdl_busy <= 1'b1;
            mdl_lat  <= 3;
            mdl_p    <= 64'(longint'($signed(mul_a)) * longint'($signed(mul_b)));
        end else if (mdl_busy) begin
            if (mdl_lat == 0) begin
                mdl_busy <= 1'b0;
                mdl_done <= !mdl_hang;
            end else begin
                mdl_lat <= mdl_lat - 1;
            end
        end
    end

    assign mul_done     = mdl_done;
    assign mul_product  = mdl_ovr_en ? mdl_ovr_p : mdl_p;
    assign mul_overflow = mdl_ovr_en;

    always @(posedge clk) begin
        if (mul_start) start_cnt <= start_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        logic acc;
        acc = 1'b0;
        in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            acc = in_ready;
            tick();
            if (acc) break;
        end
        in_valid = 1'b0;
        total++;
        if (acc !== 1'b1) $display("FAIL push_accept tag=%0d: in_ready never seen, got %b want 1", tag, acc);
        else pass_cnt++;
    endtask

    task automatic wait_result();
        int n;
        n = 0;
        while (res_valid !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        total++;
        if (res_valid !== 1'b1) $display("FAIL wait_result: res_valid=%b after %0d cycles, want 1", res_valid, n);
        else pass_cnt++;
    endtask

    task automatic accept();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++;
        if ({mul_start, res_valid, res_overflow, res_err, busy} !== 5'b0) $display("FAIL reset_flags: got %b want 00000", {mul_start, res_valid, res_overflow, res_err, busy});
        else pass_cnt++;
        total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else pass_cnt++;
        total++;
        if ({mul_a, mul_b, res_product, res_tag, jobs_done} !== '0) $display("FAIL reset_data: a=%h b=%h p=%h tag=%h jd=%0d want all 0", mul_a, mul_b, res_product, res_tag, jobs_done);
        else pass_cnt++;
        total++;
        if (fsm_state !== IDLE) $display("FAIL reset_state: got %0d want %0d", fsm_state, IDLE);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        push(32'd123, 32'd456, 4'd1);
        tick();
        total++;
        if ({mul_start, mul_a, mul_b} !== {1'b1, 32'd123, 32'd456}) $display("FAIL basic_issue: start=%b a=%0d b=%0d want 1 123 456", mul_start, mul_a, mul_b);
        else pass_cnt++;
        tick();
        total++;
        if (mul_start !== 1'b0) $display("FAIL basic_pulse_width: got %b want 0", mul_start);
        else pass_cnt++;
        wait_result();
        total++;
        if ({res_product, res_tag, res_overflow, res_err} !== {64'd56088, 4'd1, 1'b0, 1'b0}) $display("FAIL basic_result: p=%0d tag=%0d ov=%b err=%b want 56088 1 0 0", res_product, res_tag, res_overflow, res_err);
        else pass_cnt++;
        total++;
        if (jobs_done !== 16'd1) $display("FAIL basic_jobs_done: got %0d want 1", jobs_done);
        else pass_cnt++;
        accept();
        total++;
        if (res_valid !== 1'b0) $display("FAIL basic_release: res_valid=%b want 0", res_valid);
        else pass_cnt++;
        total++;
        if (start_cnt !== 1) $display("FAIL basic_start_count: got %0d want 1", start_cnt);
        else pass_cnt++;
    endtask

    task automatic test_fifo_order();
        logic acc;
        int n;
        res_ready = 1'b0;
        exp_q = '{64'hFFFF_FFFF_FFFF_24E8, 64'd35, 64'd0, 64'hFFFF_FFFF_FFF0_BDC0, 64'd1, 64'h1_0000_0000};
        exp_tag_q = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
        push(-32'sd123, 32'd456, 4'd0);
        push(-32'sd5, -32'sd7, 4'd1);
        push(32'd0, 32'd12345, 4'd2);
        push(32'd1000, -32'sd1000, 4'd3);
        push(-32'sd1, -32'sd1, 4'd4);
        for (int i = 0; i < 12; i++) tick();
        total++;
        if ({in_ready, fifo_count, res_valid, res_tag} !== {1'b0, 3'd4, 1'b1, 4'd0}) $display("FAIL fifo_full: rdy=%b cnt=%0d vld=%b tag=%0d want 0 4 1 0", in_ready, fifo_count, res_valid, res_tag);
        else pass_cnt++;
        in_a = 32'd65536; in_b = 32'd65536; in_tag = 4'd5; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        total++;
        if ({in_ready, fifo_count} !== {1'b0, 3'd4}) $display("FAIL fifo_stall: rdy=%b cnt=%0d want 0 4", in_ready, fifo_count);
        else pass_cnt++;
        res_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            if (res_valid === 1'b1) begin
                total++;
                if ({res_product, res_tag} !== {exp_q[0], exp_tag_q[0]}) $display("FAIL fifo_order: p=%h tag=%0d want %h %0d", res_product, res_tag, exp_q[0], exp_tag_q[0]);
                else pass_cnt++;
                void'(exp_q.pop_front());
                void'(exp_tag_q.pop_front());
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) in_valid = 1'b0;
            n++;
        end
        res_ready = 1'b0;
        in_valid = 1'b0;
        total++;
        if (exp_q.size() != 0) $display("FAIL fifo_drain: %0d results missing, want 0", exp_q.size());
        else pass_cnt++;
        tick();
        total++;
        if ({jobs_done, busy} !== {16'd7, 1'b0}) $display("FAIL fifo_jobs_done: jd=%0d busy=%b want 7 0", jobs_done, busy);
        else pass_cnt++;
    endtask

    task automatic test_back_pressure();
        int starts;
        int bad;
        bad = 0;
        push(32'd7, -32'sd9, 4'd9);
        push(32'd2, 32'd3, 4'd10);
        wait_result();
        starts = start_cnt;
        for (int i = 0; i < 10; i++) begin
            if ({res_valid, res_product, res_tag, mul_start} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFC1, 4'd9, 1'b0}) bad++;
            tick();
        end
        total++;
        if (bad != 0) $display("FAIL bp_stable: %0d unstable cycles, want 0", bad);
        else pass_cnt++;
        total++;
        if (start_cnt !== starts) $display("FAIL bp_no_start: starts=%0d want %0d", start_cnt, starts);
        else pass_cnt++;
        accept();
        wait_result();
        total++;
        if ({res_product, res_tag, jobs_done} !== {64'd6, 4'd10, 16'd9}) $display("FAIL bp_second: p=%0d tag=%0d jd=%0d want 6 10 9", res_product, res_tag, jobs_done);
        else pass_cnt++;
        accept();
    endtask

    task automatic test_reset_mid_job();
        int stray;
        stray = 0;
        push(32'd3, 32'd4, 4'd2);
        in_a = 32'd5; in_b = 32'd6; in_tag = 4'd3; in_valid = 1'b1;
        tick();
        in_a = 32'd7; in_b = 32'd8; in_tag = 4'd4;
        tick();
        in_valid = 1'b0;
        total++;
        if ({fsm_state, fifo_count} !== {WAIT, 3'd2}) $display("FAIL rmid_setup: state=%0d cnt=%0d want %0d 2", fsm_state, fifo_count, WAIT);
        else pass_cnt++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({res_valid, busy, in_ready, jobs_done} !== {1'b0, 1'b0, 1'b1, 16'd0}) $display("FAIL rmid_reset: vld=%b busy=%b rdy=%b jd=%0d want 0 0 1 0", res_valid, busy, in_ready, jobs_done);
        else pass_cnt++;
        for (int i = 0; i < 20; i++) begin
            if (res_valid !== 1'b0 || mul_start !== 1'b0) stray++;
            tick();
        end
        total++;
        if (stray != 0) $display("FAIL rmid_stale: %0d stray cycles, want 0", stray);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        mdl_ovr_en = 1'b1;
        mdl_ovr_p  = 64'hC000_0000_0000_0000;
        push(32'h7FFF_FFFF, 32'h8000_0000, 4'd3);
        tick();
        total++;
        if ({mul_a, mul_b} !== {32'h7FFF_FFFF, 32'h8000_0000}) $display("FAIL ovf_operands: a=%h b=%h want 7fffffff 80000000", mul_a, mul_b);
        else pass_cnt++;
        wait_result();
        total++;
        if ({res_product, res_overflow, res_tag, jobs_done} !== {64'hC000_0000_0000_0000, 1'b1, 4'd3, 16'd1}) $display("FAIL ovf_result: p=%h ov=%b tag=%0d jd=%0d want c000000000000000 1 3 1", res_product, res_overflow, res_tag, jobs_done);
        else pass_cnt++;
        accept();
        mdl_ovr_en = 1'b0;
    endtask

`ifdef MULT_TIMEOUT_EN
    task automatic test_timeout();
        mdl_hang = 1'b1;
        push(32'd5, 32'd6, 4'd4);
        in_a = 32'd2; in_b = 32'd2; in_tag = 4'd5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        total++;
        if (mul_start !== 1'b1) $display("FAIL to_issue: start=%b want 1", mul_start);
        else pass_cnt++;
        for (int i = 0; i < 80; i++) tick();
        total++;
        if (res_valid !== 1'b0) $display("FAIL to_early: res_valid=%b want 0 at 79 cycles", res_valid);
        else pass_cnt++;
        tick();
        total++;
        if ({res_valid, res_err, res_product, res_overflow, res_tag, jobs_done} !== {1'b1, 1'b1, 64'd0, 1'b0, 4'd4, 16'd2}) $display("FAIL to_abort: vld=%b err=%b p=%h ov=%b tag=%0d jd=%0d want 1 1 0 0 4 2", res_valid, res_err, res_product, res_overflow, res_tag, jobs_done);
        else pass_cnt++;
        mdl_hang = 1'b0;
        accept();
        wait_result();
        total++;
        if ({res_err, res_product, res_tag, jobs_done} !== {1'b0, 64'd4, 4'd5, 16'd3}) $display("FAIL to_next: err=%b p=%0d tag=%0d jd=%0d want 0 4 5 3", res_err, res_product, res_tag, jobs_done);
        else pass_cnt++;
        accept();
    endtask
`endif

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_tag = '0;
        res_ready = 1'b0;
        test_reset();
        test_basic();
        test_fifo_order();
        test_back_pressure();
        test_reset_mid_job();
        test_overflow();
`ifdef MULT_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
